result_axis_streamer: RTL and testbench

Downstream stage of the matrix-multiply core: after the core finishes a tile, it reads the NUM_O_ELEMENTS result words out of the core's output BRAM and streams them as one AXI-Stream packet into the S2MM FIFO. It absorbs the BRAM's 1-cycle read latency and arbitrary tready backpressure. It sustains 1 word/cycle when tready is held high and sets tlast on the final word.

---
 rtl/result_axis_streamer_pkg.sv | 20 ++
 rtl/result_axis_streamer_if.sv | 14 +
 rtl/result_axis_streamer_skid_fifo.sv | 64 ++++++
 rtl/result_axis_streamer.sv | 131 +++++++++++++
 tb/tb_result_axis_streamer.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/result_axis_streamer_pkg.sv
// Shared types and sizing helpers for the result streamer: FSM state encoding,
// word-width derivation and counter sizing.
package result_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FIN    = 2'd2
  } state_e;

  function automatic int calc_data_w(input int width, input int chunk, input int cores);
    return width * chunk * cores;
  endfunction

  // Counters must reach NUM_O_ELEMENTS itself without wrapping.
  function automatic int calc_cnt_w(input int num_elems);
    return $clog2(num_elems + 1);
  endfunction

endpackage

// File: rtl/result_axis_streamer_if.sv
// AXI-Stream master-side bundle carrying result words out of the streamer.
interface result_axis_streamer_if #(
  parameter int DATA_W = 128
);

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/result_axis_streamer_skid_fifo.sv
// Two-entry registered FIFO that absorbs the BRAM read latency; the head
// entry is a register so it can drive tdata directly.
module result_skid_fifo #(
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_tail;
  logic [1:0]        r_count;
  logic              w_pop;
  logic              w_push;

  assign w_pop  = pop && (r_count != 2'd0);
  assign w_push = push && ((r_count != 2'd2) || w_pop);

  // Storage and occupancy update; head always holds the oldest word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= {DATA_W{1'b0}};
      r_tail  <= {DATA_W{1'b0}};
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head <= din;
          end else begin
            r_tail <= din;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= din;
          end else begin
            r_head <= r_tail;
            r_tail <= din;
          end
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

  assign dout  = r_head;
  assign empty = (r_count == 2'd0);
  assign count = r_count;

endmodule

// File: rtl/result_axis_streamer.sv
// Reads a tile's result words out of the output BRAM and streams them as one
// AXI-Stream packet, tolerating the BRAM read latency and arbitrary backpressure.
module result_axis_streamer
  import result_stream_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int CHUNK_SIZE     = 4,
  parameter int NUM_CORES      = 2,
  parameter int NUM_O_ELEMENTS = 6,
  parameter int ADDR_WIDTH     = 8,
  localparam int DATA_W        = calc_data_w(WIDTH, CHUNK_SIZE, NUM_CORES)
) (
  input  logic                  aclk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_W-1:0]     rd_data,
  result_axis_streamer_if.master m_axis
);

  localparam int CNT_W = calc_cnt_w(NUM_O_ELEMENTS);

  state_e           r_state;
  logic [CNT_W-1:0] r_reads;
  logic [CNT_W-1:0] r_beats;
  logic             r_inflight;
  logic             r_busy;
  logic             r_done;

  logic [DATA_W-1:0] w_head;
  logic              w_empty;
  logic [1:0]        w_occ;
  logic              w_valid;
  logic              w_pop;
  logic              w_rd_en;
  logic [2:0]        w_pending;
  logic              w_last_beat;

  assign w_valid     = !w_empty;
  assign w_pop       = w_valid && m_axis.tready;
  assign w_last_beat = (r_beats == CNT_W'(NUM_O_ELEMENTS - 1));

  // Issue a read only if the word it returns is guaranteed a free FIFO slot.
  always_comb begin
    w_rd_en   = 1'b0;
    w_pending = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    if ((r_state == STREAM) && (r_reads < CNT_W'(NUM_O_ELEMENTS)) && (w_pending <= 3'd1)) begin
      w_rd_en = 1'b1;
    end else begin
      w_rd_en = 1'b0;
    end
  end

  // Packet sequencing: state, read/beat counters and the busy/done flags.
  always_ff @(posedge aclk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_reads    <= {CNT_W{1'b0}};
      r_beats    <= {CNT_W{1'b0}};
      r_inflight <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      r_done     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= STREAM;
            r_reads <= {CNT_W{1'b0}};
            r_beats <= {CNT_W{1'b0}};
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        STREAM: begin
          if (w_rd_en) begin
            r_reads <= r_reads + CNT_W'(1'b1);
          end else begin
            r_reads <= r_reads;
          end
          if (w_pop) begin
            r_beats <= r_beats + CNT_W'(1'b1);
            if (w_last_beat) begin
              r_state <= FIN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= STREAM;
            end
          end else begin
            r_beats <= r_beats;
          end
        end
        FIN: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  result_skid_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (aclk),
    .rst   (rst),
    .push  (r_inflight),
    .din   (rd_data),
    .pop   (w_pop),
    .dout  (w_head),
    .empty (w_empty),
    .count (w_occ)
  );

  assign busy          = r_busy;
  assign done          = r_done;
  assign rd_en         = w_rd_en;
  assign rd_addr       = ADDR_WIDTH'(r_reads);
  assign m_axis.tdata  = w_head;
  assign m_axis.tvalid = w_valid;
  assign m_axis.tlast  = w_valid && w_last_beat;

endmodule

// File: tb/tb_result_axis_streamer.sv
// Self-checking bench: table of packet scenarios plus hand-written corner
// sequences, with a scoreboard queue checking every accepted beat.
module tb_result_axis_streamer;
  import result_stream_pkg::*;

  localparam int N  = 6;
  localparam int DW = 128;
  localparam int AW = 8;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  logic          rst, start, busy, done, rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = {DW{1'b0}};
  result_axis_streamer_if #(.DATA_W(DW)) axis ();

  logic          start2, busy2, done2, rd_en2;
  logic [AW-1:0] rd_addr2;
  logic [DW-1:0] rd_data2 = {DW{1'b0}};
  result_axis_streamer_if #(.DATA_W(DW)) axis2 ();

  result_axis_streamer #(
    .WIDTH(16), .CHUNK_SIZE(4), .NUM_CORES(2), .NUM_O_ELEMENTS(N), .ADDR_WIDTH(AW)
  ) dut (
    .aclk(aclk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .m_axis(axis.master)
  );

  result_axis_streamer #(
    .WIDTH(16), .CHUNK_SIZE(4), .NUM_CORES(2), .NUM_O_ELEMENTS(1), .ADDR_WIDTH(AW)
  ) dut1 (
    .aclk(aclk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2), .m_axis(axis2.master)
  );

  // BRAM word i: low element 0x10+i, upper elements 0xC000+i.
  function automatic logic [DW-1:0] word(input int i);
    logic [15:0] lo;
    logic [15:0] hi;
    lo = 16'(i + 16);
    hi = 16'(16'hC000 + i);
    return {hi, hi, hi, hi, hi, hi, hi, lo};
  endfunction

  always @(posedge aclk) if (rd_en)  rd_data  <= word(int'(rd_addr));
  always @(posedge aclk) if (rd_en2) rd_data2 <= word(int'(rd_addr2));

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  int exp_q[$];
  int mon_beats, mon_dones, mon_reads;

  // Scoreboard monitor plus AXIS hold-while-stalled check.
  initial begin
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    int            idx;
    prev_stall = 1'b0;
    prev_data  = {DW{1'b0}};
    prev_last  = 1'b0;
    forever begin
      @(negedge aclk);
      if (rst !== 1'b0) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", axis.tvalid, 1'b1);
          check("hold_data", axis.tdata, prev_data);
          check("hold_last", axis.tlast, prev_last);
        end
        if (rd_en) mon_reads++;
        if (done) mon_dones++;
        if (axis.tvalid && axis.tready) begin
          mon_beats++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat actual=%0h expected=none", axis.tdata);
          end else begin
            idx = exp_q.pop_front();
            check("beat_data", axis.tdata, word(idx));
            check("beat_last", axis.tlast, (idx == N - 1));
          end
        end
        prev_stall = axis.tvalid && !axis.tready;
        prev_data  = axis.tdata;
        prev_last  = axis.tlast;
      end
    end
  end

  typedef struct {
    int ready_pct;
    int stall_from;
    int stall_len;
    int hold_idx;
    bit extra_start;
    bit chk_timing;
    int reps;
    int exp_beats;
    int exp_dones;
    int exp_reads;
  } vec_t;

  vec_t vecs[4];

  task automatic run_packet(input vec_t v);
    int k, off, idle;
    bit fin, in_stall, exp_en;
    mon_beats = 0;
    mon_dones = 0;
    mon_reads = 0;
    for (int i = 0; i < N; i++) exp_q.push_back(i);
    @(posedge aclk); #1;
    start = 1'b1;
    axis.tready = (v.ready_pct >= 100);
    k = cyc + 1;
    fin = 1'b0;
    idle = 0;
    for (int n = 0; n < 400 && idle < 4; n++) begin
      @(posedge aclk); #1;
      off = cyc + 1 - k;
      start = v.extra_start && (off == 2 || off == 5);
      in_stall = (v.stall_len > 0) && (off >= v.stall_from) && (off < v.stall_from + v.stall_len);
      if (in_stall) axis.tready = 1'b0;
      else if (v.ready_pct >= 100) axis.tready = 1'b1;
      else axis.tready = ($urandom_range(0, 99) < v.ready_pct);
      @(negedge aclk);
      if (v.chk_timing && off <= 10) begin
        exp_en = (off >= 1 && off <= N);
        check("t_rd_en", rd_en, exp_en);
        if (exp_en) check("t_rd_addr", rd_addr, AW'(off - 1));
        check("t_tvalid", axis.tvalid, (off >= 3 && off <= N + 2));
        check("t_tlast", axis.tlast, (off == N + 2));
        check("t_done", done, (off == N + 3));
        check("t_busy", busy, (off >= 1 && off <= N + 2));
      end
      if (in_stall) begin
        check("stall_tvalid", axis.tvalid, 1'b1);
        check("stall_tdata", axis.tdata, word(v.hold_idx));
        check("stall_rd_en", rd_en, 1'b0);
      end
      if (fin) idle++;
      if (done) fin = 1'b1;
    end
    start = 1'b0;
    check("pkt_done_seen", fin, 1'b1);
    check("pkt_beats", mon_beats, v.exp_beats);
    check("pkt_dones", mon_dones, v.exp_dones);
    check("pkt_reads", mon_reads, v.exp_reads);
    check("pkt_queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, off;
    vecs[0] = '{ready_pct:100, stall_from:0, stall_len:0, hold_idx:0, extra_start:1'b0,
                chk_timing:1'b1, reps:1, exp_beats:N, exp_dones:1, exp_reads:N};
    vecs[1] = '{ready_pct:100, stall_from:5, stall_len:5, hold_idx:2, extra_start:1'b0,
                chk_timing:1'b0, reps:1, exp_beats:N, exp_dones:1, exp_reads:N};
    vecs[2] = '{ready_pct:100, stall_from:0, stall_len:0, hold_idx:0, extra_start:1'b1,
                chk_timing:1'b1, reps:1, exp_beats:N, exp_dones:1, exp_reads:N};
    vecs[3] = '{ready_pct:50, stall_from:0, stall_len:0, hold_idx:0, extra_start:1'b0,
                chk_timing:1'b0, reps:20, exp_beats:N, exp_dones:1, exp_reads:N};

    rst = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    axis.tready = 1'b0;
    axis2.tready = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rd_en", rd_en, 1'b0);
    check("rst_rd_addr", rd_addr, {AW{1'b0}});
    check("rst_tvalid", axis.tvalid, 1'b0);
    check("rst_tlast", axis.tlast, 1'b0);
    check("rst_tdata", axis.tdata, {DW{1'b0}});
    check("rst_tvalid_n1", axis2.tvalid, 1'b0);
    @(posedge aclk); #1;
    rst = 1'b0;

    foreach (vecs[v]) begin
      for (int r = 0; r < vecs[v].reps; r++) run_packet(vecs[v]);
    end

    // Reset in the cycle after beat 3, then a clean packet.
    axis.tready = 1'b1;
    for (int i = 0; i < N; i++) exp_q.push_back(i);
    @(posedge aclk); #1;
    start = 1'b1;
    k = cyc + 1;
    for (int n = 0; n < 7; n++) begin
      @(posedge aclk); #1;
      off = cyc + 1 - k;
      start = 1'b0;
      if (off == 7) rst = 1'b1;
      @(negedge aclk);
    end
    @(posedge aclk); #1;
    rst = 1'b0;
    @(negedge aclk);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_rd_en", rd_en, 1'b0);
    check("mid_rst_rd_addr", rd_addr, {AW{1'b0}});
    check("mid_rst_tvalid", axis.tvalid, 1'b0);
    check("mid_rst_tlast", axis.tlast, 1'b0);
    check("mid_rst_tdata", axis.tdata, {DW{1'b0}});
    exp_q.delete();
    run_packet(vecs[0]);

    // Single-element packet on the second instance.
    @(posedge aclk); #1;
    start2 = 1'b1;
    k = cyc + 1;
    for (int n = 0; n < 5; n++) begin
      @(posedge aclk); #1;
      off = cyc + 1 - k;
      start2 = 1'b0;
      @(negedge aclk);
      case (off)
        1: begin
          check("n1_rd_en", rd_en2, 1'b1);
          check("n1_rd_addr", rd_addr2, {AW{1'b0}});
        end
        2: check("n1_early_valid", axis2.tvalid, 1'b0);
        3: begin
          check("n1_tvalid", axis2.tvalid, 1'b1);
          check("n1_tlast", axis2.tlast, 1'b1);
          check("n1_tdata", axis2.tdata, word(0));
          check("n1_no_done_yet", done2, 1'b0);
        end
        4: begin
          check("n1_done", done2, 1'b1);
          check("n1_after_valid", axis2.tvalid, 1'b0);
          check("n1_busy_low", busy2, 1'b0);
        end
        default: check("n1_done_pulse", done2, 1'b0);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
